ga_selection: RTL and testbench
===============================

Name: ga_selection

Overview:
- Tournament-selection engine; the producing end of the parents valid/ack interface consumed by the crossover stage.
- On each generation start it reads candidate chromosomes and fitness scores from the population memory and runs a 2-way tournament per parent.
- It emits cnfg_pairs_num parent pairs per generation, one pair per handshake, then pulses done.

Parameters:
- CHROM_MAX_W, 32, chromosome width in bits.
- FIT_SCORE_W, 8, fitness score width.
- POP_IDX_W, 5, population index width; max population is 2**POP_IDX_W.
- PAIRS_W, 6, width of the pair-count configuration.
- RAND_W, 2*POP_IDX_W, local; width of rand_data. Must not be overridden.

Ports:
- clk  in  1  system clock.
- rstn  in  1  asynchronous active-low reset.
- sw_rst  in  1  synchronous software reset, active high.
- cnfg_p  in  POP_IDX_W+1  population size.
- cnfg_pairs_num  in  PAIRS_W  number of parent pairs per generation.
- start  in  1  generation-start pulse.
- rand_data  in  RAND_W  free-running random word.
- pop_rd_en  out  1  population memory read strobe.
- pop_rd_addr  out  POP_IDX_W  population memory read index.
- pop_rd_chrom  in  CHROM_MAX_W  read chromosome; valid 1 cycle after pop_rd_en.
- pop_rd_score  in  FIT_SCORE_W  read fitness score; valid 1 cycle after pop_rd_en.
- parents_valid  out  1  parent pair available.
- parent1  out  CHROM_MAX_W  first parent.
- parent2  out  CHROM_MAX_W  second parent.
- parents_ack  in  1  consumer accepts the pair.
- busy  out  1  high outside IDLE.
- done  out  1  one-cycle pulse after the last pair is accepted.

Behaviour:
- Reset (rstn low, async) and sw_rst (sync, same effect) clear all state.
  - All outputs go to 0; FSM goes to IDLE; pair counter clears; captured parents clear.
  - Reset mid-operation drops any pending pair without producing done.
- FSM states:
  - IDLE: start=1 with cnfg_pairs_num=0 -> done pulses next cycle, stay IDLE. start=1 otherwise -> RD_A, pair_cnt=0, slot=0.
  - RD_A: sample rand_data into idx_a and idx_b. pop_rd_en=1, pop_rd_addr=idx_a. -> RD_B.
  - RD_B: pop_rd_en=1, pop_rd_addr=idx_b. Capture chrom_a and score_a. -> CMP.
  - CMP: capture chrom_b and score_b. Winner = A if score_a >= score_b (tie goes to A), else B. Write the winner to parent1 if slot=0, else to parent2. slot=0 -> toggle slot, go to RD_A. slot=1 -> OUT.
  - OUT: parents_valid=1; parent1 and parent2 held stable. On parents_ack=1, pair_cnt increments. If pair_cnt+1 == cnfg_pairs_num -> IDLE with done=1 for one cycle; else slot=0 -> RD_A.
- Index mapping, with r = the relevant rand_data half (idx_a from bits [POP_IDX_W-1:0], idx_b from bits [RAND_W-1:POP_IDX_W]):
  - r < cnfg_p -> r.
  - else if r - cnfg_p < cnfg_p -> r - cnfg_p.
  - else -> cnfg_p - 1.
  - cnfg_p <= 1 forces index 0.
- Latency: parents_valid rises on the 6th rising edge after the edge that samples start. With back-to-back acks, pair throughput is 1 pair per 7 cycles.
- Handshake:
  - parents_valid stays high until parents_ack is sampled high.
  - parents_valid is low in the cycle after the ack.
  - parents_ack while parents_valid=0 is ignored.
  - parent outputs never change while parents_valid=1.
- start while busy=1 is ignored.
- cnfg_p and cnfg_pairs_num are sampled live; software holds them stable while busy.
- done and parents_valid are never high together.
- pop_rd_en is asserted only in RD_A and RD_B.

Test Plan:
- Basic pair: cnfg_p=8, pairs=1, scores[i]=i, rand_data=0x0A3 (idx_a=3, idx_b=5) held for both tournaments -> on edge 6 parents_valid=1, parent1=parent2=chrom[5]. Ack -> done pulses, busy=0.
- Tie and wrap: cnfg_p=6, rand_data halves 7 and 1, scores equal -> idx_a=1, idx_b=1, winner is A. Halves 31 and 2 -> idx_a=5 (clamped), idx_b=2.
- Backpressure: hold parents_ack=0 for 20 cycles -> parents_valid stays 1, parents stable, no pop_rd_en. Ack -> next pair's valid appears 7 cycles later.
- Pair count: pairs=3, ack each pair immediately -> exactly 3 valid/ack handshakes, one done pulse, start ignored mid-run.
- Zero pairs: pairs=0, start -> done the next cycle, pop_rd_en never asserted.
- Resets: assert rstn low (async) while in OUT -> parents_valid=0 immediately, FSM in IDLE, no done. Repeat with sw_rst -> same result on the next edge.

Source files
------------

// File: rtl/ga_selection.sv
// Tournament-selection engine: two 2-way tournaments per parent pair, read from
// the population memory, handed to crossover over a parents valid/ack handshake.
module ga_selection #(
  parameter  int CHROM_MAX_W = 32,
  parameter  int FIT_SCORE_W = 8,
  parameter  int POP_IDX_W   = 5,
  parameter  int PAIRS_W     = 6,
  localparam int RAND_W      = 2 * POP_IDX_W
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   sw_rst,
  input  logic [POP_IDX_W:0]     cnfg_p,
  input  logic [PAIRS_W-1:0]     cnfg_pairs_num,
  input  logic                   start,
  input  logic [RAND_W-1:0]      rand_data,
  output logic                   pop_rd_en,
  output logic [POP_IDX_W-1:0]   pop_rd_addr,
  input  logic [CHROM_MAX_W-1:0] pop_rd_chrom,
  input  logic [FIT_SCORE_W-1:0] pop_rd_score,
  output logic                   parents_valid,
  output logic [CHROM_MAX_W-1:0] parent1,
  output logic [CHROM_MAX_W-1:0] parent2,
  input  logic                   parents_ack,
  output logic                   busy,
  output logic                   done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_A,
    S_RD_B,
    S_CMP,
    S_OUT
  } state_t;

  state_t                 r_state;
  state_t                 w_next_state;
  logic                   r_slot;
  logic [PAIRS_W-1:0]     r_pair_cnt;
  logic [POP_IDX_W-1:0]   r_idx_b;
  logic [CHROM_MAX_W-1:0] r_chrom_a;
  logic [FIT_SCORE_W-1:0] r_score_a;
  logic [CHROM_MAX_W-1:0] r_parent1;
  logic [CHROM_MAX_W-1:0] r_parent2;
  logic                   r_done;

  logic [POP_IDX_W-1:0]   w_idx_a;
  logic [POP_IDX_W-1:0]   w_idx_b;
  logic [CHROM_MAX_W-1:0] w_winner;
  logic                   w_last_pair;
  logic                   w_zero_pairs;

  // Folds a raw random half into [0, cnfg_p): one subtraction, then clamp.
  function automatic logic [POP_IDX_W-1:0] map_idx(input logic [POP_IDX_W-1:0] raw,
                                                   input logic [POP_IDX_W:0]   pop);
    logic [POP_IDX_W:0] ext;
    logic [POP_IDX_W:0] diff;
    logic [POP_IDX_W:0] top;
    ext  = {1'b0, raw};
    diff = ext - pop;
    top  = pop - (POP_IDX_W+1)'(1);
    if (pop <= (POP_IDX_W+1)'(1)) map_idx = '0;
    else if (ext < pop)           map_idx = raw;
    else if (diff < pop)          map_idx = diff[POP_IDX_W-1:0];
    else                          map_idx = top[POP_IDX_W-1:0];
  endfunction

  assign w_idx_a      = map_idx(rand_data[POP_IDX_W-1:0], cnfg_p);
  assign w_idx_b      = map_idx(rand_data[RAND_W-1:POP_IDX_W], cnfg_p);
  assign w_winner     = (r_score_a >= pop_rd_score) ? r_chrom_a : pop_rd_chrom;
  assign w_last_pair  = ({1'b0, r_pair_cnt} + 1'b1) == {1'b0, cnfg_pairs_num};
  assign w_zero_pairs = (cnfg_pairs_num == '0);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)       r_state <= S_IDLE;
    else if (sw_rst) r_state <= S_IDLE;
    else             r_state <= w_next_state;
  end

  // NOTE: the default assignment first keeps this block free of inferred latches.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: if (start && !w_zero_pairs) w_next_state = S_RD_A;
      S_RD_A: w_next_state = S_RD_B;
      S_RD_B: w_next_state = S_CMP;
      S_CMP:  w_next_state = r_slot ? S_OUT : S_RD_A;
      S_OUT:  if (parents_ack) w_next_state = w_last_pair ? S_IDLE : S_RD_A;
      default: w_next_state = S_IDLE;
    endcase
  end

  always_comb begin
    pop_rd_en     = 1'b0;
    pop_rd_addr   = '0;
    parents_valid = 1'b0;
    busy          = (r_state != S_IDLE);
    case (r_state)
      S_RD_A: begin
        pop_rd_en   = 1'b1;
        pop_rd_addr = w_idx_a;
      end
      S_RD_B: begin
        pop_rd_en   = 1'b1;
        pop_rd_addr = r_idx_b;
      end
      S_OUT:   parents_valid = 1'b1;
      default: ;
    endcase
  end

  // Datapath: memory data arrives one cycle after its read strobe.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_slot     <= 1'b0;
      r_pair_cnt <= '0;
      r_idx_b    <= '0;
      r_chrom_a  <= '0;
      r_score_a  <= '0;
      r_parent1  <= '0;
      r_parent2  <= '0;
      r_done     <= 1'b0;
    end else if (sw_rst) begin
      r_slot     <= 1'b0;
      r_pair_cnt <= '0;
      r_idx_b    <= '0;
      r_chrom_a  <= '0;
      r_score_a  <= '0;
      r_parent1  <= '0;
      r_parent2  <= '0;
      r_done     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            if (w_zero_pairs) begin
              r_done <= 1'b1;
            end else begin
              r_pair_cnt <= '0;
              r_slot     <= 1'b0;
            end
          end
        end
        S_RD_A: r_idx_b <= w_idx_b;
        S_RD_B: begin
          r_chrom_a <= pop_rd_chrom;
          r_score_a <= pop_rd_score;
        end
        S_CMP: begin
          if (!r_slot) begin
            r_parent1 <= w_winner;
            r_slot    <= 1'b1;
          end else begin
            r_parent2 <= w_winner;
          end
        end
        S_OUT: begin
          if (parents_ack) begin
            r_pair_cnt <= r_pair_cnt + 1'b1;
            r_slot     <= 1'b0;
            if (w_last_pair) r_done <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign parent1 = r_parent1;
  assign parent2 = r_parent2;
  assign done    = r_done;

endmodule

// File: tb/tb_ga_selection.sv
// Self-checking bench for ga_selection: transaction-level tournament model with a
// per-cycle compare process, plus directed checks with hand-computed values.
module tb_ga_selection;

  localparam int CW = 32;
  localparam int SW = 8;
  localparam int IW = 5;
  localparam int PW = 6;
  localparam int RW = 2 * IW;

  logic          clk;
  logic          rstn;
  logic          sw_rst;
  logic [IW:0]   cnfg_p;
  logic [PW-1:0] cnfg_pairs_num;
  logic          start;
  logic [RW-1:0] rand_data;
  logic          pop_rd_en;
  logic [IW-1:0] pop_rd_addr;
  logic [CW-1:0] pop_rd_chrom;
  logic [SW-1:0] pop_rd_score;
  logic          parents_valid;
  logic [CW-1:0] parent1;
  logic [CW-1:0] parent2;
  logic          parents_ack;
  logic          busy;
  logic          done;

  logic [CW-1:0] mem_chrom [32];
  logic [SW-1:0] mem_score [32];
  logic          rand_hold;
  logic [RW-1:0] rand_fixed;
  int            n_checks;
  int            n_fail;

  ga_selection dut (
    .clk            (clk),
    .rstn           (rstn),
    .sw_rst         (sw_rst),
    .cnfg_p         (cnfg_p),
    .cnfg_pairs_num (cnfg_pairs_num),
    .start          (start),
    .rand_data      (rand_data),
    .pop_rd_en      (pop_rd_en),
    .pop_rd_addr    (pop_rd_addr),
    .pop_rd_chrom   (pop_rd_chrom),
    .pop_rd_score   (pop_rd_score),
    .parents_valid  (parents_valid),
    .parent1        (parent1),
    .parent2        (parent2),
    .parents_ack    (parents_ack),
    .busy           (busy),
    .done           (done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Population memory: registered read, data valid the cycle after the strobe.
  always @(posedge clk) begin
    if (pop_rd_en) begin
      pop_rd_chrom <= mem_chrom[pop_rd_addr];
      pop_rd_score <= mem_score[pop_rd_addr];
    end
  end

  // Free-running random word, changed mid-cycle, or held for directed tests.
  initial begin
    rand_data = '0;
    forever begin
      @(posedge clk);
      #2;
      rand_data = rand_hold ? rand_fixed : RW'($urandom);
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int map_idx(input int r, input int p);
    if (p <= 1)    return 0;
    if (r < p)     return r;
    if (r - p < p) return r - p;
    return p - 1;
  endfunction

  bit          m_busy, m_valid, m_done;
  int          m_t, m_cnt, m_ib;
  logic [CW-1:0] m_p1, m_p2;

  task automatic m_clear();
    m_busy = 0; m_valid = 0; m_done = 0;
    m_t = 0; m_cnt = 0; m_ib = 0;
    m_p1 = '0; m_p2 = '0;
  endtask

  // One pair = tournament at cycle 0, tournament at cycle 3, offered from cycle 6.
  task automatic m_step();
    int ia;
    int ib;
    logic [CW-1:0] win;
    m_done = 0;
    if (!m_busy) begin
      if (start) begin
        if (cnfg_pairs_num == 0) m_done = 1;
        else begin
          m_busy = 1; m_valid = 0; m_t = 0; m_cnt = 0;
        end
      end
    end else if (m_valid) begin
      if (parents_ack) begin
        m_valid = 0;
        m_cnt++;
        if (m_cnt == int'(cnfg_pairs_num)) begin
          m_busy = 0;
          m_done = 1;
        end else m_t = 0;
      end
    end else begin
      if (m_t == 0 || m_t == 3) begin
        ia   = map_idx(int'(rand_data[IW-1:0]), int'(cnfg_p));
        ib   = map_idx(int'(rand_data[RW-1:IW]), int'(cnfg_p));
        m_ib = ib;
        win  = (mem_score[ia] >= mem_score[ib]) ? mem_chrom[ia] : mem_chrom[ib];
        if (m_t == 0) m_p1 = win;
        else          m_p2 = win;
      end
      m_t++;
      if (m_t == 6) m_valid = 1;
    end
  endtask

  initial begin
    m_clear();
    forever begin
      @(posedge clk or negedge rstn);
      if (!rstn || sw_rst) m_clear();
      else                 m_step();
    end
  end

  // Compare process: every cycle, away from the active edge.
  initial begin
    forever begin : cmp
      bit exp_en;
      int exp_addr;
      @(negedge clk);
      exp_en = m_busy && !m_valid && (m_t == 0 || m_t == 1 || m_t == 3 || m_t == 4);
      check("busy", busy, m_busy);
      check("parents_valid", parents_valid, m_valid);
      check("done", done, m_done);
      check("pop_rd_en", pop_rd_en, exp_en);
      if (exp_en) begin
        exp_addr = (m_t == 0 || m_t == 3) ? map_idx(int'(rand_data[IW-1:0]), int'(cnfg_p)) : m_ib;
        check("pop_rd_addr", pop_rd_addr, exp_addr);
      end
      if (m_valid) begin
        check("parent1", parent1, m_p1);
        check("parent2", parent2, m_p2);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_gen();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_valid(input int budget);
    int k;
    k = 0;
    while (!parents_valid && k < budget) begin
      tick();
      k++;
    end
    check("wait_valid_timeout", parents_valid, 1);
  endtask

  task automatic randomize_mem();
    for (int i = 0; i < 32; i++) begin
      mem_chrom[i] = $urandom;
      mem_score[i] = SW'($urandom_range(0, 7));
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [CW-1:0] cap1;
    logic [CW-1:0] cap2;
    int n, hs, dn, k;
    int rise [3];
    bit seen_done;

    n_checks = 0; n_fail = 0;
    rstn = 1'b0; sw_rst = 1'b0; start = 1'b0; parents_ack = 1'b0;
    cnfg_p = 8; cnfg_pairs_num = 1; rand_hold = 1'b1; rand_fixed = '0;
    for (int i = 0; i < 32; i++) begin
      mem_chrom[i] = 32'hC0DE0000 + i;
      mem_score[i] = SW'(i);
    end

    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_valid", parents_valid, 0);
    check("rst_done", done, 0);
    check("rst_rd_en", pop_rd_en, 0);
    check("rst_parent1", parent1, 0);
    check("rst_parent2", parent2, 0);
    @(negedge clk);
    #1 rstn = 1'b1;
    tick();

    // Basic pair: idx_a=3, idx_b=5, higher score wins both tournaments.
    rand_fixed = 10'h0A3;
    tick();
    start_gen();
    for (int e = 1; e <= 6; e++) begin
      tick();
      check("basic_valid_edge", parents_valid, e == 6);
    end
    check("basic_parent1", parent1, 32'hC0DE0005);
    check("basic_parent2", parent2, 32'hC0DE0005);
    parents_ack = 1'b1;
    tick();
    parents_ack = 1'b0;
    check("basic_done", done, 1);
    check("basic_valid_after_ack", parents_valid, 0);
    check("basic_busy", busy, 0);
    tick();
    check("basic_done_one_cycle", done, 0);

    // Tie and wrap: halves 7/1 -> 1/1; halves 31/2 -> 5 (clamped)/2; equal scores.
    for (int i = 0; i < 32; i++) mem_score[i] = 8'h40;
    cnfg_p = 6;
    rand_fixed = {5'd1, 5'd7};
    tick();
    start_gen();
    check("tie_addr_a", pop_rd_addr, 1);
    tick();
    check("tie_addr_b", pop_rd_addr, 1);
    tick();
    tick();
    rand_fixed = {5'd2, 5'd31};
    #2;
    check("wrap_addr_a", pop_rd_addr, 5);
    tick();
    check("wrap_addr_b", pop_rd_addr, 2);
    wait_valid(10);
    check("tie_parent1", parent1, 32'hC0DE0001);
    check("wrap_parent2", parent2, 32'hC0DE0005);
    parents_ack = 1'b1;
    tick();
    parents_ack = 1'b0;
    check("tie_done", done, 1);
    tick();

    // Backpressure: pair held stable, no reads, next pair 7 cycles after ack edge.
    randomize_mem();
    rand_hold = 1'b0;
    cnfg_p = 20; cnfg_pairs_num = 2;
    start_gen();
    wait_valid(20);
    cap1 = parent1;
    cap2 = parent2;
    repeat (20) begin
      tick();
      check("bp_valid_held", parents_valid, 1);
      check("bp_parent1_stable", parent1, cap1);
      check("bp_parent2_stable", parent2, cap2);
      check("bp_no_read", pop_rd_en, 0);
    end
    parents_ack = 1'b1;
    tick();
    parents_ack = 1'b0;
    n = 1;
    while (!parents_valid && n < 20) begin
      tick();
      n++;
    end
    check("bp_next_valid_latency", n, 7);
    parents_ack = 1'b1;
    tick();
    parents_ack = 1'b0;
    check("bp_done", done, 1);
    tick();

    // Pair count: three immediate acks, one done, start mid-run ignored.
    randomize_mem();
    cnfg_p = 32; cnfg_pairs_num = 3;
    parents_ack = 1'b1;
    start_gen();
    hs = 0; dn = 0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (parents_valid && parents_ack) begin
        if (hs < 3) rise[hs] = c;
        hs++;
      end
      if (done) dn++;
      if (c == 9)  start = 1'b1;
      if (c == 10) start = 1'b0;
    end
    parents_ack = 1'b0;
    check("pc_handshakes", hs, 3);
    check("pc_done_pulses", dn, 1);
    if (hs >= 3) begin
      check("pc_spacing_1", rise[1] - rise[0], 7);
      check("pc_spacing_2", rise[2] - rise[1], 7);
    end
    tick();

    // Zero pairs: done next cycle, never busy, no reads.
    cnfg_pairs_num = 0;
    start_gen();
    check("zero_done", done, 1);
    check("zero_busy", busy, 0);
    check("zero_rd_en", pop_rd_en, 0);
    tick();
    check("zero_done_one_cycle", done, 0);

    // Async reset while a pair is offered.
    cnfg_pairs_num = 1;
    start_gen();
    wait_valid(20);
    #3 rstn = 1'b0;
    #1;
    check("arst_valid", parents_valid, 0);
    check("arst_busy", busy, 0);
    check("arst_done", done, 0);
    check("arst_parent1", parent1, 0);
    @(negedge clk);
    #1 rstn = 1'b1;
    repeat (3) begin
      tick();
      check("arst_no_done", done, 0);
    end

    // Synchronous software reset while a pair is offered.
    start_gen();
    wait_valid(20);
    sw_rst = 1'b1;
    #1;
    check("swrst_valid_before_edge", parents_valid, 1);
    tick();
    sw_rst = 1'b0;
    check("swrst_valid", parents_valid, 0);
    check("swrst_busy", busy, 0);
    check("swrst_done", done, 0);
    check("swrst_parent1", parent1, 0);
    check("swrst_parent2", parent2, 0);
    tick();
    check("swrst_no_done", done, 0);

    // Randomised generations with random acks, checked by the model every cycle.
    for (int run = 0; run < 10; run++) begin
      randomize_mem();
      cnfg_p = ($urandom_range(0, 32));
      cnfg_pairs_num = PW'($urandom_range(1, 4));
      start_gen();
      k = 0;
      seen_done = 0;
      while (!seen_done && k < 300) begin
        parents_ack = ($urandom_range(0, 2) == 0);
        tick();
        if (done) seen_done = 1;
        k++;
      end
      parents_ack = 1'b0;
      check("rand_run_done", seen_done, 1);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
